// File: rtl/generic_down_counter.sv
// ----------------------------------------------------------------------------
// generic_down_counter
//
// Loadable down-counter. A start value is accepted through a valid/ready load
// handshake, then decremented on every enabled cycle until it reaches zero.
// Reaching zero raises a one-cycle terminal-count pulse. After the pulse the
// block either returns to idle or, with AUTO_RELOAD=1, restarts from the last
// accepted value.
//
// Parameters
//   COUNTER_SIZE : largest loadable count; larger loads saturate to it
//   AUTO_RELOAD  : 1 = restart from the stored value after terminal count
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   load_valid in   load request
//   load_value in   start value, sampled when load_valid && load_ready
//   load_ready out  block can accept a load (idle)
//   enable     in   decrement qualifier while running
//   abort      in   cancel an active count (wins over enable)
//   count      out  current count, registered
//   busy       out  block is not idle
//   tc         out  terminal-count pulse, one cycle
// ----------------------------------------------------------------------------
module generic_down_counter #(
   parameter  int COUNTER_SIZE = 5,
   parameter  bit AUTO_RELOAD  = 1'b0,
   localparam int W            = $clog2(COUNTER_SIZE + 1)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load_valid,
   input  logic [W-1:0] load_value,
   output logic         load_ready,
   input  logic         enable,
   input  logic         abort,
   output logic [W-1:0] count,
   output logic         busy,
   output logic         tc
);

   localparam logic [W-1:0] MAX_CNT = W'(COUNTER_SIZE);
   localparam logic [W-1:0] ONE     = W'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t         r_state;
   logic [W-1:0]   r_count;
   logic [W-1:0]   r_reload;
   logic [W-1:0]   w_load_sat;

   // load_value is W bits wide, so it can exceed COUNTER_SIZE when
   // COUNTER_SIZE+1 is not a power of two; clamp instead of wrapping.
   assign w_load_sat = (load_value > MAX_CNT) ? MAX_CNT : load_value;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_count  <= '0;
         r_reload <= '0;
      end else begin
         case (r_state)
            // abort is deliberately ignored here: a load in the same cycle
            // is still taken.
            S_IDLE: begin
               if (load_valid) begin
                  r_reload <= w_load_sat;
                  r_count  <= w_load_sat;
                  r_state  <= (w_load_sat != '0) ? S_RUN : S_DONE;
               end
            end
            S_RUN: begin
               if (abort) begin
                  r_count <= '0;
                  r_state <= S_IDLE;
               end else if (enable) begin
                  if (r_count <= ONE) begin
                     r_count <= '0;
                     r_state <= S_DONE;
                  end else begin
                     r_count <= r_count - ONE;
                  end
               end
            end
            // One-cycle pulse state. A zero reload value falls back to idle
            // so auto-reload cannot spin in DONE forever.
            S_DONE: begin
               if (AUTO_RELOAD && !abort && (r_reload != '0)) begin
                  r_count <= r_reload;
                  r_state <= S_RUN;
               end else begin
                  r_count <= '0;
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_count <= '0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Flags are decoded from the registered state only.
   assign count      = r_count;
   assign load_ready = (r_state == S_IDLE);
   assign busy       = (r_state != S_IDLE);
   assign tc         = (r_state == S_DONE);

endmodule

// File: tb/tb_generic_down_counter.sv
// ----------------------------------------------------------------------------
// tb_generic_down_counter
//
// Two instances: u_dut0 (AUTO_RELOAD=0) and u_dut1 (AUTO_RELOAD=1), both with
// COUNTER_SIZE=5. A behavioural model tracks each instance and is compared
// against every output on every falling edge; directed sequences add literal
// expectations that pin the model.
// ----------------------------------------------------------------------------
module tb_generic_down_counter;

   localparam int CSZ = 5;
   localparam int W   = 3;

   logic         clk   = 1'b0;
   logic         rst_n = 1'b0;
   logic         lv  [2];
   logic [W-1:0] val [2];
   logic         en  [2];
   logic         ab  [2];
   logic         rdy [2];
   logic [W-1:0] cnt [2];
   logic         bsy [2];
   logic         tcq [2];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   generic_down_counter #(.COUNTER_SIZE(CSZ), .AUTO_RELOAD(1'b0)) u_dut0 (
      .clk(clk), .rst_n(rst_n),
      .load_valid(lv[0]), .load_value(val[0]), .load_ready(rdy[0]),
      .enable(en[0]), .abort(ab[0]),
      .count(cnt[0]), .busy(bsy[0]), .tc(tcq[0])
   );

   generic_down_counter #(.COUNTER_SIZE(CSZ), .AUTO_RELOAD(1'b1)) u_dut1 (
      .clk(clk), .rst_n(rst_n),
      .load_valid(lv[1]), .load_value(val[1]), .load_ready(rdy[1]),
      .enable(en[1]), .abort(ab[1]),
      .count(cnt[1]), .busy(bsy[1]), .tc(tcq[1])
   );

   // ---------------- behavioural model ----------------
   // phase: 0 idle, 1 counting, 2 terminal-count cycle
   int m_ph  [2];
   int m_cnt [2];
   int m_rel [2];
   const int AR [2] = '{0, 1};

   function automatic int sat(input int x);
      return (x > CSZ) ? CSZ : x;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      for (int i = 0; i < 2; i++) begin
         if (!rst_n) begin
            m_ph[i] <= 0; m_cnt[i] <= 0; m_rel[i] <= 0;
         end else if (m_ph[i] == 0) begin
            if (lv[i]) begin
               m_rel[i] <= sat(int'(val[i]));
               m_cnt[i] <= sat(int'(val[i]));
               m_ph[i]  <= (sat(int'(val[i])) > 0) ? 1 : 2;
            end
         end else if (m_ph[i] == 1) begin
            if (ab[i]) begin
               m_cnt[i] <= 0; m_ph[i] <= 0;
            end else if (en[i]) begin
               m_cnt[i] <= m_cnt[i] - 1;
               if (m_cnt[i] - 1 == 0) m_ph[i] <= 2;
            end
         end else begin
            if (AR[i] == 1 && m_rel[i] > 0 && !ab[i]) begin
               m_cnt[i] <= m_rel[i]; m_ph[i] <= 1;
            end else begin
               m_cnt[i] <= 0; m_ph[i] <= 0;
            end
         end
      end
   end

   task automatic chk(input string name, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   // Per-cycle compare against the model.
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("model%0d_count", i), int'(cnt[i]), m_cnt[i]);
         chk($sformatf("model%0d_busy",  i), int'(bsy[i]), (m_ph[i] != 0) ? 1 : 0);
         chk($sformatf("model%0d_tc",    i), int'(tcq[i]), (m_ph[i] == 2) ? 1 : 0);
         chk($sformatf("model%0d_ready", i), int'(rdy[i]), (m_ph[i] == 0) ? 1 : 0);
      end
   end

   // Drive one cycle of inputs for instance sel (other instance idle), then
   // advance to the next falling edge where results of that edge are visible.
   task automatic cyc(input int sel, input bit l, input int v, input bit e,
                      input bit a);
      for (int i = 0; i < 2; i++) begin
         lv[i] = (i == sel) ? l : 1'b0;
         val[i] = (i == sel) ? W'(v) : '0;
         en[i] = (i == sel) ? e : 1'b0;
         ab[i] = (i == sel) ? a : 1'b0;
      end
      @(negedge clk);
   endtask

   task automatic lit(input string name, input int sel, input int c,
                      input int t, input int r);
      chk({name, "_count"}, int'(cnt[sel]), c);
      chk({name, "_tc"},    int'(tcq[sel]), t);
      chk({name, "_ready"}, int'(rdy[sel]), r);
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         lv[i] = 1'b0; val[i] = '0; en[i] = 1'b0; ab[i] = 1'b0;
      end
      @(negedge clk);
      @(negedge clk);
      lit("reset0", 0, 0, 0, 1);
      chk("reset0_busy", int'(bsy[0]), 0);
      lit("reset1", 1, 0, 0, 1);
      rst_n = 1'b1;
      @(negedge clk);

      // basic count: load 3
      cyc(0, 1, 3, 1, 0); lit("basic_l", 0, 3, 0, 0);
      chk("basic_busy", int'(bsy[0]), 1);
      cyc(0, 0, 0, 1, 0); lit("basic_2", 0, 2, 0, 0);
      cyc(0, 0, 0, 1, 0); lit("basic_1", 0, 1, 0, 0);
      cyc(0, 0, 0, 1, 0); lit("basic_0", 0, 0, 1, 0);
      cyc(0, 0, 0, 1, 0); lit("basic_idle", 0, 0, 0, 1);

      // enable gating: load 4, enable 1,0,0,1,1,1
      cyc(0, 1, 4, 0, 0); lit("gate_l", 0, 4, 0, 0);
      cyc(0, 0, 0, 1, 0); lit("gate_e1", 0, 3, 0, 0);
      cyc(0, 0, 0, 0, 0); lit("gate_e0a", 0, 3, 0, 0);
      cyc(0, 0, 0, 0, 0); lit("gate_e0b", 0, 3, 0, 0);
      cyc(0, 0, 0, 1, 0); lit("gate_e2", 0, 2, 0, 0);
      cyc(0, 0, 0, 1, 0); lit("gate_e3", 0, 1, 0, 0);
      cyc(0, 0, 0, 1, 0); lit("gate_tc", 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 0); lit("gate_idle", 0, 0, 0, 1);

      // zero load
      cyc(0, 1, 0, 1, 0); lit("zero_tc", 0, 0, 1, 0);
      cyc(0, 0, 0, 1, 0); lit("zero_idle", 0, 0, 0, 1);

      // saturating load 7 -> 5, with a load pulse during RUN
      cyc(0, 1, 7, 1, 0); lit("sat_l", 0, 5, 0, 0);
      cyc(0, 0, 0, 1, 0); lit("sat_4", 0, 4, 0, 0);
      cyc(0, 1, 1, 1, 0); lit("sat_ign", 0, 3, 0, 0);
      cyc(0, 0, 0, 1, 0); lit("sat_2", 0, 2, 0, 0);
      cyc(0, 0, 0, 1, 0); lit("sat_1", 0, 1, 0, 0);
      cyc(0, 0, 0, 1, 0); lit("sat_tc", 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 0); lit("sat_idle", 0, 0, 0, 1);

      // abort at count 2 together with enable, then immediate reload
      cyc(0, 1, 5, 1, 0); lit("ab_l", 0, 5, 0, 0);
      cyc(0, 0, 0, 1, 0);
      cyc(0, 0, 0, 1, 0);
      cyc(0, 0, 0, 1, 0); lit("ab_2", 0, 2, 0, 0);
      cyc(0, 0, 0, 1, 1); lit("ab_idle", 0, 0, 0, 1);
      cyc(0, 1, 2, 1, 0); lit("ab_reload", 0, 2, 0, 0);
      cyc(0, 0, 0, 1, 0);
      cyc(0, 0, 0, 1, 0); lit("ab_tc", 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 0);
      // abort in idle does not block a load
      cyc(0, 1, 1, 1, 1); lit("abidle_l", 0, 1, 0, 0);
      cyc(0, 0, 0, 1, 0); lit("abidle_tc", 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 0); lit("abidle_idle", 0, 0, 0, 1);

      // auto-reload instance: load 2
      cyc(1, 1, 2, 1, 0); lit("ar_l", 1, 2, 0, 0);
      cyc(1, 0, 0, 1, 0); lit("ar_1", 1, 1, 0, 0);
      cyc(1, 0, 0, 1, 0); lit("ar_tc", 1, 0, 1, 0);
      cyc(1, 0, 0, 1, 0); lit("ar_re2", 1, 2, 0, 0);
      cyc(1, 0, 0, 1, 0); lit("ar_re1", 1, 1, 0, 0);
      cyc(1, 0, 0, 1, 0); lit("ar_tc2", 1, 0, 1, 0);
      cyc(1, 0, 0, 1, 0); lit("ar_re2b", 1, 2, 0, 0);
      cyc(1, 0, 0, 1, 1); lit("ar_abort", 1, 0, 0, 1);
      cyc(1, 1, 0, 1, 0); lit("ar_zero_tc", 1, 0, 1, 0);
      cyc(1, 0, 0, 1, 0); lit("ar_zero_idle", 1, 0, 0, 1);
      cyc(1, 0, 0, 1, 0); lit("ar_zero_stay", 1, 0, 0, 1);
      // abort during the DONE cycle suppresses the reload
      cyc(1, 1, 1, 1, 0); lit("ar_d_l", 1, 1, 0, 0);
      cyc(1, 0, 0, 1, 0); lit("ar_d_tc", 1, 0, 1, 0);
      cyc(1, 0, 0, 1, 1); lit("ar_d_abort", 1, 0, 0, 1);

      // async reset mid-RUN at count 3
      cyc(0, 1, 5, 1, 0);
      cyc(0, 0, 0, 1, 0);
      cyc(0, 0, 0, 1, 0); lit("rst_pre", 0, 3, 0, 0);
      #2 rst_n = 1'b0;
      #1 lit("rst_async", 0, 0, 0, 1);
      chk("rst_async_busy", int'(bsy[0]), 0);
      @(negedge clk);
      rst_n = 1'b1;
      cyc(0, 1, 3, 1, 0); lit("post_l", 0, 3, 0, 0);
      cyc(0, 0, 0, 1, 0); lit("post_2", 0, 2, 0, 0);
      cyc(0, 0, 0, 1, 0); lit("post_1", 0, 1, 0, 0);
      cyc(0, 0, 0, 1, 0); lit("post_tc", 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 0); lit("post_idle", 0, 0, 0, 1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/generic_down_counter.md
Name: generic_down_counter

Overview:
- Loadable down-counter: accepts a start value through a valid/ready load handshake, then decrements on each enabled cycle to zero.
- Flags terminal count with a one-cycle pulse, then either returns to idle or reloads.
- Counterpart to the free-running up-counter used for window/address stepping in the CNN datapath. Used where a consumer must wait a programmable number of enabled cycles (e.g. drain of a line buffer, remaining kernel taps).

Parameters:
- COUNTER_SIZE, 5: maximum loadable count value. W = $clog2(COUNTER_SIZE+1) is the count width.
- AUTO_RELOAD, 0: 1 = after terminal count, reload the last accepted value and keep counting. 0 = return to idle.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- load_valid  in  1  load request.
- load_value  in  W  start value. Sampled when load_valid && load_ready.
- load_ready  out  1  block can accept a load.
- enable  in  1  decrement qualifier in RUN.
- abort  in  1  cancel an active count.
- count  out  W  current count (registered).
- busy  out  1  state != IDLE.
- tc  out  1  terminal-count pulse, one cycle.

Behaviour:
- Reset (async assert, sync release): state=IDLE, count=0, load_ready=1, busy=0, tc=0, stored reload value=0.
- States: IDLE, RUN, DONE. All outputs are registered or decoded from registered state only; there are no combinational input->output paths.
- IDLE:
  - load_ready=1, count=0.
  - On load_valid=1 at edge N: v = min(load_value, COUNTER_SIZE). Values above COUNTER_SIZE saturate.
  - v is stored as reload value and count<=v.
  - Next state: RUN if v>0; DONE if v==0.
  - abort has no effect in IDLE, and the load is still accepted.
- RUN:
  - load_ready=0. load_valid is ignored; no back-pressure beyond load_ready.
  - enable=1 and count>1: count<=count-1.
  - enable=1 and count==1: count<=0, state<=DONE.
  - enable=0: hold count and state.
  - abort=1: count<=0, state<=IDLE, no tc. abort has priority over enable in the same cycle.
- DONE:
  - Lasts exactly one cycle. tc=1, count=0, load_ready=0.
  - AUTO_RELOAD=0: next state IDLE.
  - AUTO_RELOAD=1 and reload value>0: count<=reload value, state<=RUN.
  - AUTO_RELOAD=1 and reload value==0: state<=IDLE, which prevents an endless DONE loop.
  - abort in DONE: state<=IDLE, count stays 0. tc for this cycle is already asserted.
- Latency: load accepted at edge N with v>0 and enable held high gives:
  - count=v after N
  - count=0 and tc=1 after N+v
  - IDLE (load_ready=1) after N+v+1, or count=v again after N+v+1 when AUTO_RELOAD=1.
- Zero load: DONE after N, tc=1 for one cycle, IDLE after N+1.
- count never wraps below 0 and never exceeds COUNTER_SIZE.
- Reset asserted mid-RUN: immediate return to reset values, no tc.

Test Plan:
- Basic count, COUNTER_SIZE=5, AUTO_RELOAD=0, enable=1, load 3 -> count 3,2,1,0 on successive cycles; tc=1 exactly in the count=0 cycle; load_ready=1 one cycle later; busy high for 4 cycles.
- Enable gating: load 4, enable pattern 1,0,0,1,1,1 -> count 4,3,3,3,2,1,0; tc once, after the 4th enabled cycle.
- Boundaries: load 0 -> tc=1 on the next cycle, never enters RUN. Load 7 with COUNTER_SIZE=5 (W=3) -> count starts at 5 and reaches 0 after 5 enabled cycles. load_valid pulsed during RUN -> ignored, count unaffected.
- Abort: load 5; at count=2, assert abort together with enable -> count=0 and IDLE next cycle, tc never asserted, next load accepted immediately.
- Auto-reload, AUTO_RELOAD=1, load 2, enable=1 -> count 2,1,0(tc),2,1,0(tc)... repeats with load_ready=0. Abort in RUN -> IDLE. Load 0 -> single tc, then IDLE.
- Async reset asserted mid-RUN at count=3 between clock edges -> count=0, busy=0, load_ready=1, tc=0 immediately. After release, first load behaves as in the basic count scenario.
